// File: rtl/pc_unit.sv
// Program counter for the multicycle MIPS datapath: next-PC select, return-address stack,
// exception entry/return with misaligned-target trapping. All outputs are registered.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0040_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h8000_0180,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       pc_sel,
    input  logic [WIDTH-1:0] branch_tgt,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] reg_tgt,
    input  logic             call,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] bad_addr,
    output logic             addr_err,
    output logic             ras_empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_top;
    logic [CW-1:0]    ras_cnt;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] jmp_tgt;
    logic [WIDTH-1:0] tgt;
    logic             ras_has;
    logic             do_pop;
    logic             misalign;

    always_comb begin
        pc_plus4        = pc + WIDTH'(4);
        // J-type keeps the upper nibble of PC+4 and replaces the low 28 bits
        jmp_tgt         = pc_plus4;
        jmp_tgt[27:0]   = {jump_index, 2'b00};
        ras_has         = (ras_cnt != '0);
        case (pc_sel)
            3'd1:    tgt = branch_tgt;
            3'd2:    tgt = jmp_tgt;
            3'd3:    tgt = reg_tgt;
            3'd4:    tgt = ras_has ? ras_mem[ras_top] : reg_tgt;
            default: tgt = pc_plus4;
        endcase
        misalign = (tgt[1:0] != 2'b00);
        do_pop   = (pc_sel == 3'd4) && ras_has;
    end

    assign ras_empty = (ras_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VECTOR;
            epc      <= '0;
            bad_addr <= '0;
            addr_err <= 1'b0;
            ras_top  <= '0;
            ras_cnt  <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            addr_err <= 1'b0;
            if (exc_req) begin
                pc  <= EXC_VECTOR;
                epc <= pc;
            end else if (eret) begin
                pc <= epc;
            end else if (enable) begin
                if (misalign) begin
                    pc       <= EXC_VECTOR;
                    epc      <= pc;
                    bad_addr <= tgt;
                    addr_err <= 1'b1;
                end else begin
                    pc <= tgt;
                    if (call && do_pop) begin
                        ras_mem[ras_top] <= pc_plus4;
                    end else if (call) begin
                        // full stack: pointer wraps onto the oldest entry
                        ras_mem[ras_top + PW'(1)] <= pc_plus4;
                        ras_top <= ras_top + PW'(1);
                        if (ras_cnt != RAS_FULL) begin
                            ras_cnt <= ras_cnt + CW'(1);
                        end
                    end else if (do_pop) begin
                        ras_top <= ras_top - PW'(1);
                        ras_cnt <= ras_cnt - CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  pc_sel;
    logic [31:0] branch_tgt;
    logic [25:0] jump_index;
    logic [31:0] reg_tgt;
    logic        call;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad_addr;
    logic        addr_err;
    logic        ras_empty;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pc_sel     (pc_sel),
        .branch_tgt (branch_tgt),
        .jump_index (jump_index),
        .reg_tgt    (reg_tgt),
        .call       (call),
        .exc_req    (exc_req),
        .eret       (eret),
        .pc         (pc),
        .epc        (epc),
        .bad_addr   (bad_addr),
        .addr_err   (addr_err),
        .ras_empty  (ras_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pc_sel = 3'd0; branch_tgt = '0; jump_index = '0;
        reg_tgt = '0; call = 1'b0; exc_req = 1'b0; eret = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_epc", epc, 32'h0);
        chk("rst_bad", bad_addr, 32'h0);
        chk1("rst_aerr", addr_err, 1'b0);
        chk1("rst_empty", ras_empty, 1'b1);

        // sequential fetch
        reset = 1'b0; enable = 1'b1; pc_sel = 3'd0;
        tick(); chk("seq1", pc, 32'h0040_0004);
        tick(); chk("seq2", pc, 32'h0040_0008);
        tick(); chk("seq3", pc, 32'h0040_000C);
        pc_sel = 3'd5;
        tick(); chk("sel5_as_0", pc, 32'h0040_0010);

        // jal then return
        pc_sel = 3'd2; jump_index = 26'h0100040; call = 1'b1;
        tick(); chk("jal_pc", pc, 32'h0040_0100); chk1("jal_nonempty", ras_empty, 1'b0);
        pc_sel = 3'd4; call = 1'b0;
        tick(); chk("ret_pc", pc, 32'h0040_0014); chk1("ret_empty", ras_empty, 1'b1);

        // five nested calls overflow a depth-4 stack
        pc_sel = 3'd3; call = 1'b1;
        reg_tgt = 32'h0041_0000; tick();
        reg_tgt = 32'h0042_0000; tick();
        reg_tgt = 32'h0043_0000; tick();
        reg_tgt = 32'h0044_0000; tick();
        reg_tgt = 32'h0045_0000; tick();
        chk("call5_pc", pc, 32'h0045_0000);
        pc_sel = 3'd4; call = 1'b0; reg_tgt = 32'h0050_0000;
        tick(); chk("pop1", pc, 32'h0044_0004);
        tick(); chk("pop2", pc, 32'h0043_0004);
        tick(); chk("pop3", pc, 32'h0042_0004);
        tick(); chk("pop4", pc, 32'h0041_0004); chk1("pop4_empty", ras_empty, 1'b1);
        tick(); chk("pop5_fallback", pc, 32'h0050_0000);

        // push and pop in the same cycle replaces the top
        pc_sel = 3'd3; call = 1'b1; reg_tgt = 32'h0046_0000;
        tick(); chk("call_a", pc, 32'h0046_0000);
        pc_sel = 3'd4; call = 1'b1;
        tick(); chk("pushpop_pc", pc, 32'h0050_0004); chk1("pushpop_nonempty", ras_empty, 1'b0);
        call = 1'b0;
        tick(); chk("pushpop_top", pc, 32'h0046_0004); chk1("pushpop_empty", ras_empty, 1'b1);

        // misaligned register target traps without touching the RAS
        pc_sel = 3'd1; branch_tgt = 32'h0040_0020;
        tick(); chk("br_pc", pc, 32'h0040_0020);
        pc_sel = 3'd3; reg_tgt = 32'h0040_0102; call = 1'b1;
        tick();
        chk("mis_pc", pc, 32'h8000_0180);
        chk("mis_epc", epc, 32'h0040_0020);
        chk("mis_bad", bad_addr, 32'h0040_0102);
        chk1("mis_aerr", addr_err, 1'b1);
        chk1("mis_nopush", ras_empty, 1'b1);
        enable = 1'b0; call = 1'b0;
        tick(); chk1("aerr_pulse", addr_err, 1'b0); chk("hold_exc", pc, 32'h8000_0180);

        // exc_req beats eret and enable
        eret = 1'b1;
        tick(); chk("eret1", pc, 32'h0040_0020);
        eret = 1'b0; enable = 1'b1; pc_sel = 3'd1; branch_tgt = 32'h0040_0030;
        tick(); chk("br30", pc, 32'h0040_0030);
        exc_req = 1'b1; eret = 1'b1;
        tick(); chk("exc_pc", pc, 32'h8000_0180); chk("exc_epc", epc, 32'h0040_0030);
        exc_req = 1'b0; eret = 1'b1; enable = 1'b0;
        tick(); chk("eret2", pc, 32'h0040_0030);
        eret = 1'b0;

        // enable low holds everything
        enable = 1'b1; pc_sel = 3'd1; branch_tgt = 32'h0040_0040; call = 1'b1;
        tick(); chk("call_b", pc, 32'h0040_0040);
        enable = 1'b0; branch_tgt = 32'h0000_1000;
        tick(); tick(); tick();
        chk("hold_pc", pc, 32'h0040_0040); chk1("hold_nonempty", ras_empty, 1'b0);
        enable = 1'b1; pc_sel = 3'd4; call = 1'b0; reg_tgt = 32'h0050_0000;
        tick(); chk("hold_ras", pc, 32'h0040_0034); chk1("hold_ras_empty", ras_empty, 1'b1);

        // PC+4 wraps
        pc_sel = 3'd1; branch_tgt = 32'hFFFF_FFFC;
        tick(); pc_sel = 3'd0;
        tick(); chk("wrap", pc, 32'h0000_0000);

        // reset mid-stream
        pc_sel = 3'd1; branch_tgt = 32'h0040_0044; call = 1'b1;
        tick(); chk1("pre_rst_nonempty", ras_empty, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_pc", pc, 32'h0040_0000);
        chk1("mid_rst_empty", ras_empty, 1'b1);
        chk("mid_rst_epc", epc, 32'h0);
        chk("mid_rst_bad", bad_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
